// File: rtl/relu_pkg.sv
// Shared fixed-point constants and the ReLU-clamp pass-mask rule used by the
// forward check and the backward gradient gate.
package relu_pkg;

    localparam int unsigned INTEGER_WIDTH      = 16;
    localparam int unsigned DEF_FRACTION_WIDTH = 15;
    localparam int unsigned DEF_DATA_WIDTH     = 1 + INTEGER_WIDTH + DEF_FRACTION_WIDTH;
    localparam int unsigned WORD_WIDTH         = 64;

    // Operands arrive sign-extended to WORD_WIDTH so one function serves any DATA_WIDTH.
    function automatic logic relu_pass_mask(input logic [WORD_WIDTH-1:0] x,
                                            input logic [WORD_WIDTH-1:0] max_v,
                                            input int unsigned           frac_w);
        logic [WORD_WIDTH-1:0] mag_mask;
        logic [WORD_WIDTH-1:0] frac_mask;
        logic [WORD_WIDTH-1:0] x_int;
        logic [WORD_WIDTH-1:0] m_int;
        logic [WORD_WIDTH-1:0] x_frac;
        logic [WORD_WIDTH-1:0] m_frac;
        logic                  lt;
        mag_mask  = {1'b0, {(WORD_WIDTH-1){1'b1}}};
        frac_mask = (WORD_WIDTH'(1) << frac_w) - WORD_WIDTH'(1);
        x_int     = (x & mag_mask) >> frac_w;
        m_int     = (max_v & mag_mask) >> frac_w;
        x_frac    = x & frac_mask;
        m_frac    = max_v & frac_mask;
        lt        = (x_int < m_int) | ((x_int == m_int) & (x_frac < m_frac));
        return ~x[WORD_WIDTH-1] & ~max_v[WORD_WIDTH-1] & lt;
    endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// 1-bit circular buffer of pass masks with an occupancy counter that has
// Depth+1 states, so full and empty never alias.
module relu_mask_fifo #(
    parameter int unsigned Depth = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       mask_i,
    input  logic                       pop_i,
    output logic                       mask_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign mask_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = mask_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/relu_backprop_gate.sv
// Backward ReLU-clamp gate: stores a pass bit per forward element and zeroes
// returning gradients whose forward input fell outside [0, max_relu).
module relu_backprop_gate
    import relu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned FRACTION_WIDTH = DEF_FRACTION_WIDTH,
    parameter int unsigned MASK_DEPTH     = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_flush,
    input  logic [DATA_WIDTH-1:0]           i_max_relu,
    output logic                            o_invalid_max_relu,
    input  logic                            i_fwd_valid,
    output logic                            o_fwd_ready,
    input  logic [DATA_WIDTH-1:0]           i_fwd_data,
    input  logic                            i_grad_valid,
    output logic                            o_grad_ready,
    input  logic [DATA_WIDTH-1:0]           i_grad_data,
    output logic                            o_grad_valid,
    input  logic                            i_grad_ready,
    output logic [DATA_WIDTH-1:0]           o_grad_data,
    output logic [$clog2(MASK_DEPTH+1)-1:0] o_mask_count
);

    logic                  fwd_mask;
    logic                  rd_mask;
    logic                  full, empty;
    logic                  push, pop;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    assign o_invalid_max_relu = i_max_relu[DATA_WIDTH-1];
    assign fwd_mask = relu_pass_mask(WORD_WIDTH'($signed(i_fwd_data)),
                                     WORD_WIDTH'($signed(i_max_relu)), FRACTION_WIDTH);

    assign o_fwd_ready  = ~full;
    assign o_grad_ready = ~empty & (~out_valid_q | i_grad_ready);
    assign push         = i_fwd_valid & o_fwd_ready;
    assign pop          = i_grad_valid & o_grad_ready;

    relu_mask_fifo #(
        .Depth (MASK_DEPTH)
    ) u_mask_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (i_flush),
        .push_i  (push),
        .mask_i  (fwd_mask),
        .pop_i   (pop),
        .mask_o  (rd_mask),
        .count_o (o_mask_count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (i_flush) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= rd_mask ? i_grad_data : '0;
        end else if (out_valid_q && i_grad_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign o_grad_valid = out_valid_q;
    assign o_grad_data  = out_data_q;

endmodule

// File: tb/tb_relu_backprop_gate.sv
// Randomized and directed checks of relu_backprop_gate against a queue-based model.
module tb_relu_backprop_gate;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] MAX6  = 32'h0003_0000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic [31:0] i_max_relu;
    logic        o_invalid_max_relu;
    logic        i_fwd_valid;
    logic        o_fwd_ready;
    logic [31:0] i_fwd_data;
    logic        i_grad_valid;
    logic        o_grad_ready;
    logic [31:0] i_grad_data;
    logic        o_grad_valid;
    logic        i_grad_ready;
    logic [31:0] o_grad_data;
    logic [2:0]  o_mask_count;

    int n_checks = 0;
    int n_fail   = 0;

    bit          mq[$];
    logic        mo_v;
    logic [31:0] mo_d;

    relu_backprop_gate #(
        .DATA_WIDTH     (DW),
        .FRACTION_WIDTH (15),
        .MASK_DEPTH     (DEPTH)
    ) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_flush            (i_flush),
        .i_max_relu         (i_max_relu),
        .o_invalid_max_relu (o_invalid_max_relu),
        .i_fwd_valid        (i_fwd_valid),
        .o_fwd_ready        (o_fwd_ready),
        .i_fwd_data         (i_fwd_data),
        .i_grad_valid       (i_grad_valid),
        .o_grad_ready       (o_grad_ready),
        .i_grad_data        (i_grad_data),
        .o_grad_valid       (o_grad_valid),
        .i_grad_ready       (i_grad_ready),
        .o_grad_data        (o_grad_data),
        .o_mask_count       (o_mask_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Gradient passes only for 0 <= x < max with a non-negative max.
    function automatic bit ref_pass(input logic [31:0] x, input logic [31:0] m);
        return ($signed(m) >= 0) && ($signed(x) >= 0) && ($signed(x) < $signed(m));
    endfunction

    function automatic bit mdl_fwd_ready();
        return mq.size() != DEPTH;
    endfunction

    function automatic bit mdl_grad_ready(input logic gr);
        return (mq.size() != 0) && (!mo_v || gr);
    endfunction

    task automatic model_clear();
        mq.delete();
        mo_v = 1'b0;
        mo_d = '0;
    endtask

    task automatic compare_outputs();
        check_eq("fwd_ready", 64'(o_fwd_ready), 64'(mdl_fwd_ready()));
        check_eq("grad_ready", 64'(o_grad_ready), 64'(mdl_grad_ready(i_grad_ready)));
        check_eq("grad_valid", 64'(o_grad_valid), 64'(mo_v));
        check_eq("mask_count", 64'(o_mask_count), 64'(mq.size()));
        check_eq("invalid_max", 64'(o_invalid_max_relu), 64'(i_max_relu[31]));
        if (mo_v) check_eq("grad_data", 64'(o_grad_data), 64'(mo_d));
    endtask

    // Called just after a falling edge: drive, check, advance the model, cross one rising edge.
    task automatic step(input logic fv, input logic [31:0] fd, input logic gv,
                        input logic [31:0] gd, input logic gr, input logic fl);
        bit push, pop, m;
        i_fwd_valid  = fv;
        i_fwd_data   = fd;
        i_grad_valid = gv;
        i_grad_data  = gd;
        i_grad_ready = gr;
        i_flush      = fl;
        #1;
        compare_outputs();
        push = fv && mdl_fwd_ready();
        pop  = gv && mdl_grad_ready(gr);
        if (fl) begin
            model_clear();
        end else begin
            if (pop) begin
                m    = mq.pop_front();
                mo_v = 1'b1;
                mo_d = m ? gd : 32'h0;
            end else if (mo_v && gr) begin
                mo_v = 1'b0;
            end
            if (push) mq.push_back(ref_pass(fd, i_max_relu));
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic idle(input logic gr);
        step(1'b0, 32'h0, 1'b0, 32'h0, gr, 1'b0);
    endtask

    initial begin
        logic [31:0] xs[4];
        logic [31:0] exp1[4];
        logic [31:0] x, m;
        xs   = '{32'h0000_8000, 32'hFFFF_8000, 32'h0003_0000, 32'h0002_FFFF};
        exp1 = '{32'h0000_4000, 32'h0, 32'h0, 32'h0000_4000};

        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_max_relu = MAX6;
        i_fwd_valid = 1'b0;
        i_fwd_data = '0;
        i_grad_valid = 1'b0;
        i_grad_data = '0;
        i_grad_ready = 1'b0;
        model_clear();
        #1;
        check_eq("rst_grad_valid", 64'(o_grad_valid), 64'h0);
        check_eq("rst_grad_data", 64'(o_grad_data), 64'h0);
        check_eq("rst_count", 64'(o_mask_count), 64'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check_eq("rst_fwd_ready", 64'(o_fwd_ready), 64'h1);
        @(negedge i_clk);

        // Clamp pass/zero ordering.
        for (int i = 0; i < 4; i++) step(1'b1, xs[i], 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, (i < 4), 32'h0000_4000, 1'b1, 1'b0);
            if (i < 4) begin
                check_eq("t1_valid", 64'(o_grad_valid), 64'h1);
                check_eq("t1_data", 64'(o_grad_data), 64'(exp1[i]));
            end
        end
        idle(1'b1);

        // Full, held push, then simultaneous push+pop.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_1000 * i, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t2_count_full", 64'(o_mask_count), 64'd4);
        check_eq("t2_fwd_ready", 64'(o_fwd_ready), 64'h0);
        step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t2_held_count", 64'(o_mask_count), 64'd4);
        step(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0011, 1'b1, 1'b0);
        check_eq("t2_pop_count", 64'(o_mask_count), 64'd3);
        step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t2_refill", 64'(o_mask_count), 64'd4);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0022, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0033, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0044, 1'b1, 1'b0);
        check_eq("t2_pushpop_count", 64'(o_mask_count), 64'd2);

        // Backpressure holds the output.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
            check_eq("t3_valid_hold", 64'(o_grad_valid), 64'h1);
            check_eq("t3_data_hold", 64'(o_grad_data), 64'h44);
            check_eq("t3_count_hold", 64'(o_mask_count), 64'd2);
        end

        // Empty: gradient must wait for a mask.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 32'h0000_0777, 1'b1, 1'b0);
        step(1'b1, 32'h0, 1'b1, 32'h0000_0777, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0777, 1'b1, 1'b0);
        check_eq("t4_zero_pass", 64'(o_grad_data), 64'h777);
        idle(1'b1);

        // Invalid max zeroes every mask.
        i_max_relu = 32'h8000_0000;
        step(1'b1, 32'h0000_8000, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t5_invalid", 64'(o_invalid_max_relu), 64'h1);
        step(1'b0, 32'h0, 1'b1, 32'h0001_0000, 1'b1, 1'b0);
        check_eq("t5_zeroed", 64'(o_grad_data), 64'h0);
        idle(1'b1);
        i_max_relu = MAX6;

        // Flush with count=3 and a pending output.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0800, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_0099, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t6_flush_count", 64'(o_mask_count), 64'd0);
        check_eq("t6_flush_valid", 64'(o_grad_valid), 64'h0);

        // Async reset mid-stream.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0800, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_00AA, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("t6_arst_valid", 64'(o_grad_valid), 64'h0);
        check_eq("t6_arst_data", 64'(o_grad_data), 64'h0);
        check_eq("t6_arst_count", 64'(o_mask_count), 64'h0);
        model_clear();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 19))
                0:       m = $urandom;
                1:       m = 32'h0;
                2:       m = 32'h7FFF_FFFF;
                default: m = MAX6;
            endcase
            i_max_relu = m;
            case ($urandom_range(0, 5))
                0:       x = 32'h0;
                1:       x = m;
                2:       x = m - 32'd1;
                3:       x = $urandom;
                4:       x = $urandom_range(0, 32'h0004_0000);
                default: x = 32'h8000_0000 | $urandom;
            endcase
            step(($urandom_range(0, 9) < 7), x, ($urandom_range(0, 9) < 7), $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
